branch_resolve_unit: RTL and testbench

Parametrised, buffered branch resolution unit for the out-of-order core. It accepts ready branch operations from the branch reservation station and resolves direction, target and misprediction against the predictor's guess. Results are queued in a DEPTH-entry result FIFO and handed to the PC/commit logic through a valid/ready handshake. It also keeps saturating resolution statistics and supports a flush from the misprediction recovery path.

---
 rtl/branch_resolve_unit.sv | 146 ++++++++++++++
 tb/tb_branch_resolve_unit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Branch resolution unit: resolves direction/target/mispredict and queues results in a DEPTH-entry FIFO.
// Optional feature macro: BRANCH_JALR_EN (adds JALR resolution against pred_addr).
`ifndef OpBus
`define OpBus [3:0]
`endif
`ifndef BEQ
`define BEQ  4'd1
`endif
`ifndef BNE
`define BNE  4'd2
`endif
`ifndef BLT
`define BLT  4'd3
`endif
`ifndef BGE
`define BGE  4'd4
`endif
`ifndef BLTU
`define BLTU 4'd5
`endif
`ifndef BGEU
`define BGEU 4'd6
`endif
`ifndef JALR
`define JALR 4'd7
`endif

module branch_resolve_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 2,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic `OpBus      op,
    input  logic [XLEN-1:0]  opnd_a,
    input  logic [XLEN-1:0]  opnd_b,
    input  logic [XLEN-1:0]  imm,
    input  logic [XLEN-1:0]  pc,
    input  logic [TAG_W-1:0] tag,
    input  logic             pred,
    input  logic [XLEN-1:0]  pred_addr,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [TAG_W-1:0] res_tag,
    output logic [XLEN-1:0]  res_addr,
    output logic             res_mis,
    output logic [XLEN-1:0]  res_link,
    output logic [CNT_W-1:0] stat_total,
    output logic [CNT_W-1:0] stat_mis
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  addr;
        logic             mis;
        logic [XLEN-1:0]  link;
    } res_t;

    res_t [DEPTH-1:0] mem;
    res_t             new_e;
    res_t             head;
    logic [PW-1:0]    wptr, rptr;
    logic [PW:0]      count;
    logic             taken, push, pop;

    // One taken bit feeds both target and mispredict so their signedness can't diverge.
    always_comb begin
        taken = 1'b0;
        case (op)
            `BEQ:  taken = (opnd_a == opnd_b);
            `BNE:  taken = (opnd_a != opnd_b);
            `BLT:  taken = ($signed(opnd_a) <  $signed(opnd_b));
            `BGE:  taken = ($signed(opnd_a) >= $signed(opnd_b));
            `BLTU: taken = (opnd_a <  opnd_b);
            `BGEU: taken = (opnd_a >= opnd_b);
            default: taken = 1'b0;
        endcase
        new_e.tag  = tag;
        new_e.link = pc + XLEN'(4);
        new_e.addr = taken ? (pc + imm) : (pc + XLEN'(4));
        new_e.mis  = taken ^ pred;
`ifdef BRANCH_JALR_EN
        if (op == `JALR) begin
            new_e.addr = (opnd_a + imm) & {{(XLEN-1){1'b1}}, 1'b0};
            new_e.mis  = (new_e.addr != pred_addr);
        end
`endif
    end

`ifndef BRANCH_JALR_EN
    logic unused_pred_addr;
    assign unused_pred_addr = ^pred_addr;
`endif

    assign in_ready  = (count != FULL);
    assign res_valid = (count != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = res_valid && res_ready;

    assign head      = mem[rptr];
    assign res_tag   = res_valid ? head.tag  : '0;
    assign res_addr  = res_valid ? head.addr : '0;
    assign res_mis   = res_valid && head.mis;
    assign res_link  = res_valid ? head.link : '0;

    always_ff @(posedge clk) begin
        if (push && !rst)
            mem[wptr] <= new_e;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            stat_total <= '0;
            stat_mis   <= '0;
        end else begin
            // Statistics survive flush; only accepted ops count.
            if (push && stat_total != '1)
                stat_total <= stat_total + 1'b1;
            if (push && new_e.mis && stat_mis != '1)
                stat_mis <= stat_mis + 1'b1;
            if (flush) begin
                wptr  <= '0;
                rptr  <= '0;
                count <= '0;
            end else begin
                if (push) wptr <= wptr + 1'b1;
                if (pop)  rptr <= rptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomised + directed bench for branch_resolve_unit against a queue-based reference model.
`ifndef OpBus
`define OpBus [3:0]
`endif
`ifndef BEQ
`define BEQ  4'd1
`endif
`ifndef BNE
`define BNE  4'd2
`endif
`ifndef BLT
`define BLT  4'd3
`endif
`ifndef BGE
`define BGE  4'd4
`endif
`ifndef BLTU
`define BLTU 4'd5
`endif
`ifndef BGEU
`define BGEU 4'd6
`endif
`ifndef JALR
`define JALR 4'd7
`endif

module tb_branch_resolve_unit;
    localparam int XLEN = 32, TAG_W = 2, DEPTH = 2, CNT_W = 16, SCW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, flush, in_valid, res_ready, pred;
    logic `OpBus      op;
    logic [XLEN-1:0]  opnd_a, opnd_b, imm, pc, pred_addr;
    logic [TAG_W-1:0] tag;
    logic             in_ready, res_valid, res_mis;
    logic [TAG_W-1:0] res_tag;
    logic [XLEN-1:0]  res_addr, res_link;
    logic [CNT_W-1:0] stat_total, stat_mis;
    logic             s_in_ready, s_res_valid, s_res_mis;
    logic [TAG_W-1:0] s_res_tag;
    logic [XLEN-1:0]  s_res_addr, s_res_link;
    logic [SCW-1:0]   s_stat_total, s_stat_mis;

    branch_resolve_unit #(.XLEN(XLEN), .TAG_W(TAG_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .opnd_a(opnd_a), .opnd_b(opnd_b), .imm(imm), .pc(pc), .tag(tag),
        .pred(pred), .pred_addr(pred_addr), .res_valid(res_valid), .res_ready(res_ready),
        .res_tag(res_tag), .res_addr(res_addr), .res_mis(res_mis), .res_link(res_link),
        .stat_total(stat_total), .stat_mis(stat_mis));

    // Narrow-counter twin shares all stimulus; used for saturation checks.
    branch_resolve_unit #(.XLEN(XLEN), .TAG_W(TAG_W), .DEPTH(DEPTH), .CNT_W(SCW)) dut_s (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
        .op(op), .opnd_a(opnd_a), .opnd_b(opnd_b), .imm(imm), .pc(pc), .tag(tag),
        .pred(pred), .pred_addr(pred_addr), .res_valid(s_res_valid), .res_ready(res_ready),
        .res_tag(s_res_tag), .res_addr(s_res_addr), .res_mis(s_res_mis), .res_link(s_res_link),
        .stat_total(s_stat_total), .stat_mis(s_stat_mis));

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  addr;
        logic             mis;
        logic [XLEN-1:0]  link;
    } exp_t;

    exp_t        q[$];
    int unsigned tot, misc, stot, smis;
    int          n_tests = 0, n_fail = 0;

    task automatic chk(input string t, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", t, got, exp);
        end
    endtask

    function automatic exp_t ref_res(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                     input logic [31:0] im, input logic [31:0] p, input logic pr,
                                     input logic [31:0] pa, input logic [1:0] tg);
        exp_t    e;
        bit      tk;
        longint  nxt;
        tk = 0;
        case (o)
            `BEQ:  tk = (a == b);
            `BNE:  tk = (a != b);
            `BLT:  tk = (int'(a) <  int'(b));
            `BGE:  tk = (int'(a) >= int'(b));
            `BLTU: tk = (longint'(a) <  longint'(b));
            `BGEU: tk = (longint'(a) >= longint'(b));
            default: tk = 0;
        endcase
        nxt    = tk ? (longint'(p) + longint'(im)) : (longint'(p) + 4);
        e.tag  = tg;
        e.addr = nxt[31:0];
        e.mis  = tk ^ pr;
        nxt    = longint'(p) + 4;
        e.link = nxt[31:0];
`ifdef BRANCH_JALR_EN
        if (o == `JALR) begin
            nxt    = (longint'(a) + longint'(im)) % 64'h1_0000_0000;
            e.addr = nxt[31:0] & 32'hFFFF_FFFE;
            e.mis  = (e.addr != pa);
        end
`else
        if (pa == 32'hDEAD_0000) e.tag = tg;
`endif
        return e;
    endfunction

    task automatic setin(input logic v, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im, input logic [31:0] p, input logic [1:0] tg,
                         input logic pr, input logic [31:0] pa);
        in_valid = v; op = o; opnd_a = a; opnd_b = b; imm = im; pc = p; tag = tg;
        pred = pr; pred_addr = pa;
    endtask

    // Check outputs mid-cycle, then advance the model across the coming edge.
    task automatic cyc();
        exp_t e;
        bit   acc, pp;
        @(negedge clk);
        chk("res_valid", res_valid, q.size() != 0);
        chk("in_ready", in_ready, q.size() < DEPTH);
        if (q.size() != 0) begin
            chk("res_tag", res_tag, q[0].tag);
            chk("res_addr", res_addr, q[0].addr);
            chk("res_mis", res_mis, q[0].mis);
            chk("res_link", res_link, q[0].link);
        end
        chk("stat_total", stat_total, tot);
        chk("stat_mis", stat_mis, misc);
        chk("s_stat_total", s_stat_total, stot);
        chk("s_stat_mis", s_stat_mis, smis);
        if (rst) begin
            q.delete();
            tot = 0; misc = 0; stot = 0; smis = 0;
        end else begin
            acc = in_valid && (q.size() < DEPTH) && !flush;
            pp  = (q.size() != 0) && res_ready;
            e   = ref_res(op, opnd_a, opnd_b, imm, pc, pred, pred_addr, tag);
            if (acc) begin
                if (tot < 65535) tot++;
                if (stot < 15) stot++;
                if (e.mis && misc < 65535) misc++;
                if (e.mis && smis < 15) smis++;
            end
            if (flush) q.delete();
            else begin
                if (pp) void'(q.pop_front());
                if (acc) q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    int unsigned saved;

    initial begin
        rst = 1; flush = 0; res_ready = 0;
        setin(0, 4'd0, 0, 0, 0, 0, 0, 0, 0);
        tot = 0; misc = 0; stot = 0; smis = 0;
        @(posedge clk); #1;
        cyc();
        chk("rst_tag", res_tag, 0);
        chk("rst_addr", res_addr, 0);
        chk("rst_link", res_link, 0);
        chk("rst_mis", res_mis, 0);
        rst = 0;

        // BLTU taken backwards, predicted not-taken
        setin(1, `BLTU, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFF8, 32'h200, 2'd0, 1'b0, 0);
        cyc();
        in_valid = 0;
        chk("bltu_valid", res_valid, 1);
        chk("bltu_addr", res_addr, 32'h1F8);
        chk("bltu_mis", res_mis, 1);
        chk("bltu_total", stat_total, 1);
        chk("bltu_smis", stat_mis, 1);
        res_ready = 1; cyc(); res_ready = 0;

        // BGE with -1 vs 1 is signed not-taken
        setin(1, `BGE, 32'hFFFF_FFFF, 32'h1, 32'h20, 32'h100, 2'd1, 1'b1, 0);
        cyc();
        in_valid = 0;
        chk("bge_addr", res_addr, 32'h104);
        chk("bge_mis", res_mis, 1);
        res_ready = 1; cyc(); res_ready = 0;

        // Fill to DEPTH with consumer stalled, then drain
        for (int t = 1; t <= 2; t++) begin
            setin(1, `BEQ, 32'h5, 32'h5, 32'h10, 32'h300 + 32'(t), 2'(t), 1'b1, 0);
            cyc();
        end
        chk("full_rdy", in_ready, 0);
        setin(1, `BEQ, 32'h5, 32'h5, 32'h10, 32'h303, 2'd3, 1'b1, 0);
        cyc();
        chk("full_rdy2", in_ready, 0);
        chk("full_head1", res_tag, 1);
        res_ready = 1;
        cyc();
        chk("drain_head2", res_tag, 2);
        chk("drain_rdy", in_ready, 1);
        cyc();
        chk("drain_head3", res_tag, 3);
        in_valid = 0;
        cyc();
        chk("drain_empty", res_valid, 0);
        res_ready = 0;

        // Flush with two queued and a same-cycle input
        for (int t = 0; t < 2; t++) begin
            setin(1, `BNE, 32'h1, 32'h2, 32'h40, 32'h500, 2'(t), 1'b0, 0);
            cyc();
        end
        saved = tot;
        flush = 1; res_ready = 1;
        setin(1, `BNE, 32'h7, 32'h8, 32'h40, 32'h600, 2'd2, 1'b0, 0);
        cyc();
        flush = 0; in_valid = 0; res_ready = 0;
        chk("flush_valid", res_valid, 0);
        chk("flush_rdy", in_ready, 1);
        chk("flush_total", stat_total, saved);
        cyc();

`ifdef BRANCH_JALR_EN
        setin(1, `JALR, 32'h1001, 32'h0, 32'h2, 32'h400, 2'd1, 1'b0, 32'h1002);
        cyc();
        chk("jalr_addr", res_addr, 32'h1002);
        chk("jalr_mis", res_mis, 0);
        chk("jalr_link", res_link, 32'h404);
        res_ready = 1;
        setin(1, `JALR, 32'h1001, 32'h0, 32'h2, 32'h400, 2'd2, 1'b0, 32'h1000);
        cyc();
        in_valid = 0;
        chk("jalr_mis2", res_mis, 1);
        cyc();
        res_ready = 0;
`endif

        // Counter saturation on the narrow twin
        rst = 1; cyc(); rst = 0;
        res_ready = 1;
        for (int i = 0; i < 17; i++) begin
            setin(1, 4'd0, 32'h0, 32'h0, 32'h0, 32'h700, 2'(i), 1'b1, 0);
            cyc();
            if (i == 14) chk("sat_at15", s_stat_mis, 4'hF);
        end
        in_valid = 0;
        chk("sat_hold", s_stat_mis, 4'hF);
        chk("sat_wide", stat_mis, 17);
        cyc();
        res_ready = 0;

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] a, b;
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom();
            b = ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom());
            setin($urandom_range(0, 3) != 0, 4'($urandom_range(0, 9)), a, b,
                  ($urandom_range(0, 1) != 0) ? $urandom() : 32'($urandom_range(0, 64)) - 32'd32,
                  $urandom(), 2'($urandom()), 1'($urandom()),
                  ($urandom_range(0, 1) != 0) ? ((a + 32'd2) & 32'hFFFF_FFFE) : $urandom());
            res_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            rst       = ($urandom_range(0, 499) == 0);
            cyc();
        end
        rst = 0; flush = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
